rand_range_sampler: RTL and testbench
=====================================

Name: rand_range_sampler

Overview:
- Downstream consumer of the free-running 7-bit LFSR output. Turns the per-cycle pseudo-random word into an on-demand, unbiased value in [0, range-1] for game logic (spawn position, dice, target pick).
- Uses rejection sampling with a bounded retry count, then a multi-cycle subtractive fold as fallback.
- Uses a req/valid/ack handshake toward the consumer.

Parameters:
- WIDTH, 7, width of rand_in, range and value; matches the LFSR output width.
- MAX_TRIES, 8, rejected samples allowed before falling back to FOLD; legal 1..255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- rand_in  in  WIDTH  pseudo-random word, new value every cycle from the LFSR.
- req  in  1  request a new value; sampled only in IDLE.
- range  in  WIDTH  exclusive upper bound N; latched when req is accepted.
- ack  in  1  consumer accepts value; meaningful only while valid=1.
- value  out  WIDTH  result, 0 <= value < range_q; holds until the next result is loaded.
- valid  out  1  result available; held high until ack.
- busy  out  1  high in SAMPLE or FOLD.
- err  out  1  high with valid when the latched range was 0.
- folded  out  1  high with valid when the result came from FOLD, not direct accept.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; value=0, valid=0, busy=0, err=0, folded=0; try counter=0; range_q=0.
  - Reset wins over every other event, including mid-SAMPLE/FOLD and valid awaiting ack. Any in-flight request is dropped.
- States: IDLE, SAMPLE, FOLD, HOLD.
- IDLE:
  - req=1 and range!=0: range_q<=range, tries<=0, go to SAMPLE.
  - req=1 and range=0: value<=0, err<=1, valid<=1, go to HOLD.
- SAMPLE (busy=1), each cycle compares the current rand_in against range_q:
  - rand_in < range_q: value<=rand_in, folded<=0, valid<=1, go to HOLD.
  - Otherwise tries<=tries+1. If tries==MAX_TRIES-1, fold_reg<=rand_in and go to FOLD.
- FOLD (busy=1), one subtraction per cycle:
  - fold_reg >= range_q: fold_reg<=fold_reg-range_q.
  - Otherwise value<=fold_reg, folded<=1, valid<=1, go to HOLD.
  - Worst case is 127 cycles (range_q=1, sample=127).
- HOLD: valid=1. On ack=1, valid<=0, err<=0, folded<=0, go to IDLE next edge; value is retained.
- Latency: req high at edge k (IDLE) gives valid high after edge k+1 if the first sample is accepted. Each rejection adds 1 cycle; the fold adds 1 cycle plus the number of subtractions.
- req while not IDLE is ignored, not queued. range changes after acceptance have no effect.
- req and ack are both high in HOLD: ack is processed and req is ignored. Back-to-back requests need one IDLE cycle.
- Arithmetic is unsigned WIDTH-bit. Subtraction never underflows, because it is guarded by the compare.
- range=1 always yields 0.

Optional Feature:
- Macro: RAND_SAMPLER_NO_REPEAT_EN.
- When defined:
  - A last_value register (reset 0, flag last_valid reset 0) is updated on every ack.
  - In SAMPLE, a candidate equal to last_value with last_valid=1 and range_q>1 counts as a rejection.
  - In FOLD, if the result equals last_value (same conditions), value<=(result+1 == range_q) ? 0 : result+1.
- When undefined: no last_value logic; repeats are permitted.

Test Plan:
- Reset mid-FOLD: range=1, rand_in held 127 for 8 cycles, rst_n=0 during FOLD -> next cycle state IDLE, valid=0, busy=0, value=0.
- Direct accept: range=10, req one cycle, rand_in=7 on the next edge -> valid=1 after 2 edges, value=7, folded=0. Hold ack=0 for 5 cycles -> value stays 7, valid stays 1.
- Retry then accept: range=10, rand_in sequence 100, 55, 3 -> valid on the 3rd SAMPLE cycle, value=3, busy high for 3 cycles.
- Fallback fold: range=10, rand_in held at 123 for MAX_TRIES=8 cycles -> FOLD runs 12 subtractions, then value=3, folded=1.
- Error and ignore: range=0 with req -> valid=1, err=1, value=0. A second req during HOLD is ignored. After ack, err=0.
- With RAND_SAMPLER_NO_REPEAT_EN: last acked value 4, range=6, rand_in sequence 4, 2 -> value=2. Fold case yielding 4 -> value=5. Fold case with range=5 yielding 4 -> value=0.

Source files
------------

// File: rtl/rand_range_sampler.sv
// Turns a free-running LFSR word into an unbiased value in [0, range-1] by rejection
// sampling, then a subtractive fold. Optional macro: RAND_SAMPLER_NO_REPEAT_EN (suppress repeats).
module rand_range_sampler #(
  parameter int WIDTH     = 7,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rand_in,
  input  logic             req,
  input  logic [WIDTH-1:0] range,
  input  logic             ack,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             busy,
  output logic             err,
  output logic             folded
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SAMPLE = 2'd1;
  localparam logic [1:0] FOLD   = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] range_q;
  logic [WIDTH-1:0] fold_reg;
  logic [7:0]       tries;

  logic             last_try;
  logic             sample_repeat;
  logic             fold_repeat;
  logic [WIDTH-1:0] fold_bump;
  logic [WIDTH-1:0] fold_result;

  assign busy     = (state == SAMPLE) || (state == FOLD);
  assign last_try = (tries == 8'(MAX_TRIES - 1));

`ifdef RAND_SAMPLER_NO_REPEAT_EN
  logic [WIDTH-1:0] last_value;
  logic             last_valid;

  // A range of 1 has only one legal answer, so repeats must be allowed there.
  assign sample_repeat = last_valid && (range_q > WIDTH'(1)) && (rand_in == last_value);
  assign fold_repeat   = last_valid && (range_q > WIDTH'(1)) && (fold_reg == last_value);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_value <= '0;
      last_valid <= 1'b0;
    end else if (state == HOLD && ack) begin
      last_value <= value;
      last_valid <= 1'b1;
    end
  end
`else
  assign sample_repeat = 1'b0;
  assign fold_repeat   = 1'b0;
`endif

  // fold_reg < range_q when this is used, so the increment cannot wrap.
  assign fold_bump   = fold_reg + WIDTH'(1);
  assign fold_result = !fold_repeat            ? fold_reg :
                       (fold_bump == range_q)  ? '0       : fold_bump;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    if (!rst_n) begin
      state    <= IDLE;
      value    <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      folded   <= 1'b0;
      range_q  <= '0;
      fold_reg <= '0;
      tries    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (range != '0) begin
              range_q <= range;
              tries   <= '0;
              state   <= SAMPLE;
            end else begin
              range_q <= '0;
              value   <= '0;
              err     <= 1'b1;
              folded  <= 1'b0;
              valid   <= 1'b1;
              state   <= HOLD;
            end
          end
        end

        SAMPLE: begin
          if (rand_in < range_q && !sample_repeat) begin
            value  <= rand_in;
            folded <= 1'b0;
            valid  <= 1'b1;
            state  <= HOLD;
          end else begin
            tries <= tries + 8'd1;
            if (last_try) begin
              fold_reg <= rand_in;
              state    <= FOLD;
            end
          end
        end

        FOLD: begin
          if (fold_reg >= range_q) begin
            fold_reg <= fold_reg - range_q;
          end else begin
            value  <= fold_result;
            folded <= 1'b1;
            valid  <= 1'b1;
            state  <= HOLD;
          end
        end

        HOLD: begin
          // ack wins; a simultaneous req is dropped, not queued.
          if (ack) begin
            valid  <= 1'b0;
            err    <= 1'b0;
            folded <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed-vector bench for rand_range_sampler with hand-computed expectations.
// Extra vectors run when RAND_SAMPLER_NO_REPEAT_EN is defined.
module tb_rand_range_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] rand_in;
  logic       req;
  logic [6:0] range;
  logic       ack;
  logic [6:0] value;
  logic       valid;
  logic       busy;
  logic       err;
  logic       folded;

  int errors = 0;
  int checks = 0;

  rand_range_sampler #(.WIDTH(7), .MAX_TRIES(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rand_in (rand_in),
    .req     (req),
    .range   (range),
    .ack     (ack),
    .value   (value),
    .valid   (valid),
    .busy    (busy),
    .err     (err),
    .folded  (folded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [6:0] r);
    req   = 1'b1;
    range = r;
    tick();
    req = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Counts edges until valid rises, bounded by limit.
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Holds rand_in for MAX_TRIES rejected samples, leaving the DUT in FOLD.
  task automatic reject_all(input logic [6:0] r);
    rand_in = r;
    for (int i = 0; i < 8; i++) tick();
  endtask

  int n;

  initial begin
    rst_n   = 1'b0;
    rand_in = '0;
    req     = 1'b0;
    range   = '0;
    ack     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_value", value, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_folded", folded, 0);

    // Reset in the middle of a long fold.
    do_req(7'd1);
    reject_all(7'd127);
    check("fold_entry_busy", busy, 1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midfold_rst_valid", valid, 0);
    check("midfold_rst_busy", busy, 0);
    check("midfold_rst_value", value, 0);
    tick();
    check("midfold_rst_stays_idle", busy, 0);

    // Direct accept; a later range change must not matter.
    do_req(7'd10);
    check("direct_busy", busy, 1);
    rand_in = 7'd7;
    range   = 7'd2;
    tick();
    check("direct_valid", valid, 1);
    check("direct_value", value, 7);
    check("direct_folded", folded, 0);
    check("direct_busy_done", busy, 0);
    rand_in = 7'd1;
    for (int i = 0; i < 5; i++) tick();
    check("hold_value", value, 7);
    check("hold_valid", valid, 1);
    do_ack();
    check("ack_valid", valid, 0);
    check("ack_value_kept", value, 7);

    // Fallback fold: 123 mod 10 after 12 subtractions plus one load edge.
    do_req(7'd10);
    reject_all(7'd123);
    check("fold_valid_pending", valid, 0);
    wait_valid(300, n);
    check("fold_cycles", n, 13);
    check("fold_value", value, 3);
    check("fold_folded", folded, 1);
    do_ack();
    check("fold_ack_folded", folded, 0);

    // Zero range error; req during HOLD ignored.
    do_req(7'd0);
    check("err_valid", valid, 1);
    check("err_err", err, 1);
    check("err_value", value, 0);
    check("err_busy", busy, 0);
    req     = 1'b1;
    range   = 7'd10;
    rand_in = 7'd5;
    tick();
    check("hold_req_ignored_busy", busy, 0);
    check("hold_req_ignored_valid", valid, 1);
    ack = 1'b1;
    tick();
    req = 1'b0;
    ack = 1'b0;
    check("err_ack_err", err, 0);
    check("err_ack_valid", valid, 0);
    tick();
    check("req_not_queued", busy, 0);
    check("req_not_queued_value", value, 0);

    // Retry twice, then accept.
    do_req(7'd10);
    n = busy ? 1 : 0;
    rand_in = 7'd100;
    tick();
    n += busy ? 1 : 0;
    check("retry1_valid", valid, 0);
    rand_in = 7'd55;
    tick();
    n += busy ? 1 : 0;
    rand_in = 7'd3;
    tick();
    check("retry_busy_cycles", n, 3);
    check("retry_valid", valid, 1);
    check("retry_value", value, 3);
    check("retry_busy_done", busy, 0);
    check("retry_folded", folded, 0);
    do_ack();

    // Boundary range=1 worst case: 127 subtractions plus one load edge.
    do_req(7'd1);
    reject_all(7'd127);
    wait_valid(300, n);
    check("range1_cycles", n, 128);
    check("range1_value", value, 0);
    check("range1_folded", folded, 1);
    do_ack();

`ifdef RAND_SAMPLER_NO_REPEAT_EN
    do_req(7'd10);
    rand_in = 7'd4;
    tick();
    check("nr_seed_value", value, 4);
    do_ack();
    do_req(7'd6);
    rand_in = 7'd4;
    tick();
    check("nr_repeat_rejected", valid, 0);
    rand_in = 7'd2;
    tick();
    check("nr_sample_value", value, 2);
    do_ack();

    do_req(7'd10);
    rand_in = 7'd4;
    tick();
    do_ack();
    do_req(7'd6);
    reject_all(7'd124);
    wait_valid(300, n);
    check("nr_fold_bump_value", value, 5);
    do_ack();

    do_req(7'd10);
    rand_in = 7'd4;
    tick();
    do_ack();
    do_req(7'd5);
    reject_all(7'd124);
    wait_valid(300, n);
    check("nr_fold_wrap_value", value, 0);
    do_ack();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
